// File: rtl/fft_vga_pkg.sv
// fft_vga_pkg: bin RAM geometry shared with the VGA renderer,
// plus the bin writer FSM state type (RD/RDWAIT with FFT_BIN_WRITER_PEAK_HOLD_EN).
package fft_vga_pkg;

  localparam int BIN_ADDR_W = 10;
  localparam int BIN_DATA_W = 32;
  localparam int BIN_COUNT  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
    ,
    ST_RD     = 2'd2,
    ST_RDWAIT = 2'd3
`endif
  } wr_state_e;

endpackage

// File: rtl/fft_bin_writer.sv
// fft_bin_writer: drains the FFT magnitude stream into the bin RAM,
// one Avalon-MM word write per bin, and flags frame completion.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   bin_valid/ready/data    stream input (ready only while idle)
//   bin_sop/bin_eop         frame markers (sop restarts at bin 0)
//   avm_*                   Avalon-MM master to the RAM s1 port
//   frame_done              1-cycle pulse after the eop bin
//   overrun/clr_overrun     sticky bin-index overflow flag, clear
//
// Build option FFT_BIN_WRITER_PEAK_HOLD_EN: read-modify-write each bin,
// storing max(new, stored); sop bins overwrite unconditionally.
module fft_bin_writer
  import fft_vga_pkg::*;
#(
  parameter int ADDR_W    = BIN_ADDR_W,
  parameter int DATA_W    = BIN_DATA_W,
  parameter int NUM_BINS  = BIN_COUNT,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                bin_valid,
  output logic                bin_ready,
  input  logic [DATA_W-1:0]   bin_data,
  input  logic                bin_sop,
  input  logic                bin_eop,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  output logic                frame_done,
  output logic                overrun,
  input  logic                clr_overrun
);

  // One extra bit so NUM_BINS == 2**ADDR_W is representable.
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LP_NUM =
    IDX_W'(NUM_BINS);
  localparam logic [ADDR_W-1:0] LP_BASE =
    ADDR_W'(BASE_ADDR);

  wr_state_e          r_state;
  logic [IDX_W-1:0]   r_index;
  logic               r_eop;
  logic               r_ready;
  logic               r_write;
  logic               r_done;
  logic               r_overrun;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;

  logic               w_xfer;
  logic [IDX_W-1:0]   w_eff;
  logic               w_fit;

  // r_ready is high exactly while idle (and low in reset).
  assign w_xfer = bin_valid && r_ready;
  assign w_eff  = bin_sop ? '0 : r_index;
  assign w_fit  = (w_eff < LP_NUM);

`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
  logic               r_read;
  logic               r_sop;
  logic [DATA_W-1:0]  r_bin;
  logic [DATA_W-1:0]  w_merge;

  // sop bins start the frame fresh; others keep the peak.
  assign w_merge = (r_sop || (r_bin > avm_readdata))
                 ? r_bin : avm_readdata;
  assign avm_read = r_read;
`else
  logic w_unused_rd;

  assign w_unused_rd = ^avm_readdata;
  assign avm_read    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_index   <= '0;
      r_eop     <= 1'b0;
      r_ready   <= 1'b0;
      r_write   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
      r_read    <= 1'b0;
      r_sop     <= 1'b0;
      r_bin     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      // A new overrun later in this block overrides the clear.
      if (clr_overrun) r_overrun <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_eop <= bin_eop;
            if (w_fit) begin
              r_index <= w_eff;
              r_ready <= 1'b0;
              r_addr  <= LP_BASE + w_eff[ADDR_W-1:0];
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
              r_sop   <= bin_sop;
              r_bin   <= bin_data;
              r_read  <= 1'b1;
              r_state <= ST_RD;
`else
              r_wdata <= bin_data;
              r_write <= 1'b1;
              r_state <= ST_WRITE;
`endif
            end else begin
              // Dropped bin; eop still closes the frame.
              r_overrun <= 1'b1;
              r_index   <= bin_eop ? '0 : w_eff;
              r_done    <= bin_eop;
            end
          end
        end
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
        ST_RD: begin
          if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          // Fixed read latency of one: data is valid now.
          r_wdata <= w_merge;
          r_write <= 1'b1;
          r_state <= ST_WRITE;
        end
`endif
        ST_WRITE: begin
          if (!avm_waitrequest) begin
            r_write <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= r_eop;
            r_index <= r_eop ? '0 : r_index + IDX_W'(1);
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bin_ready      = r_ready;
  assign avm_address    = r_addr;
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = '1;
  assign frame_done     = r_done;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_fft_bin_writer.sv
// tb_fft_bin_writer: scoreboard bench for fft_bin_writer,
// with a RAM slave model and a bin-level reference model.
module tb_fft_bin_writer;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int NB   = 4;
  localparam int BASE = 0;
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
  localparam int LP_GAP = 4;
`else
  localparam int LP_GAP = 2;
`endif

  logic          clk;
  logic          reset_n;
  logic          bin_valid;
  logic          bin_ready;
  logic [DW-1:0] bin_data;
  logic          bin_sop;
  logic          bin_eop;
  logic [AW-1:0] avm_address;
  logic          avm_write;
  logic          avm_read;
  logic [DW-1:0] avm_writedata;
  logic [3:0]    avm_byteenable;
  logic [DW-1:0] avm_readdata;
  logic          avm_waitrequest;
  logic          frame_done;
  logic          overrun;
  logic          clr_overrun;

  fft_bin_writer #(
    .ADDR_W(AW), .DATA_W(DW),
    .NUM_BINS(NB), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .bin_valid(bin_valid), .bin_ready(bin_ready),
    .bin_data(bin_data), .bin_sop(bin_sop),
    .bin_eop(bin_eop),
    .avm_address(avm_address),
    .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .frame_done(frame_done), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          eop;
    logic [DW-1:0] old;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_ram   [1024];
  logic [DW-1:0] slave_ram [1024];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_idx = 0;
  logic ov_model = 0;
  logic drop_fd = 0;
  int stall_left = 0;
  bit rnd_wait = 0;
  int stall_cycles = 0;
  bit chk_gap = 0;
  int prev_xfer = -1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // RAM slave: random/forced stalls, read latency one.
  initial begin : slave
    logic rd_pend;
    logic [AW-1:0] rd_addr;
    logic wq;
    rd_pend = 0;
    rd_addr = '0;
    avm_waitrequest = 0;
    avm_readdata = '0;
    forever begin
      @(negedge clk);
      if (rd_pend) avm_readdata = slave_ram[rd_addr];
      else avm_readdata = $urandom;
      rd_pend = 0;
      wq = 0;
      if (stall_left > 0 && avm_write) begin
        wq = 1;
        stall_left--;
      end else if (rnd_wait) begin
        wq = ($urandom_range(0, 3) == 0);
      end
      avm_waitrequest = wq;
      if (reset_n && avm_read && !wq) begin
        rd_pend = 1;
        rd_addr = avm_address;
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted write.
  initial begin : monitor
    logic fd_exp;
    logic held_v;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    int rd_acc;
    int wr_acc;
    logic [AW-1:0] last_rd;
    exp_t ex;
    fd_exp = 0;
    held_v = 0;
    h_addr = '0;
    h_data = '0;
    rd_acc = 0;
    wr_acc = 0;
    last_rd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        fd_exp = 0;
        held_v = 0;
        rd_acc = 0;
        wr_acc = 0;
      end else begin
        chk("frame_done", frame_done, fd_exp);
        fd_exp = 0;
        if (drop_fd) begin
          fd_exp = 1;
          drop_fd = 0;
        end
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
        if (avm_read && !avm_waitrequest) begin
          rd_acc++;
          last_rd = avm_address;
        end
`else
        chk("read_tied0", avm_read, 0);
`endif
        if (avm_write) begin
          chk("ready_in_write", bin_ready, 0);
          if (held_v) begin
            chk("hold_addr", avm_address, h_addr);
            chk("hold_data", avm_writedata, h_data);
          end
          if (avm_waitrequest) begin
            held_v = 1;
            h_addr = avm_address;
            h_data = avm_writedata;
            stall_cycles++;
          end else begin
            held_v = 0;
            if (q.size() == 0) begin
              chk("unexpected_write", 1, 0);
            end else begin
              ex = q.pop_front();
              chk("wr_addr", avm_address, ex.addr);
              chk("wr_data", avm_writedata, ex.data);
              chk("wr_be", avm_byteenable, 4'hF);
              fd_exp = ex.eop;
            end
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
            chk("rd_before_wr", rd_acc, wr_acc + 1);
            chk("rd_addr", last_rd, avm_address);
`endif
            wr_acc++;
            slave_ram[avm_address] = avm_writedata;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model at bin granularity, applied per transfer.
  task automatic model(input logic [DW-1:0] dd,
                       input logic ss, input logic ee,
                       input logic cc);
    int eff;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    exp_t e;
    eff = ss ? 0 : m_idx;
    if (eff < NB) begin
      a = AW'((BASE + eff) % (1 << AW));
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
      if (ss) wd = dd;
      else wd = (dd > ref_ram[a]) ? dd : ref_ram[a];
`else
      wd = dd;
`endif
      e.addr = a;
      e.data = wd;
      e.eop = ee;
      e.old = ref_ram[a];
      q.push_back(e);
      ref_ram[a] = wd;
      m_idx = ee ? 0 : eff + 1;
      if (cc) ov_model = 0;
    end else begin
      ov_model = 1;
      if (ee) begin
        drop_fd = 1;
        m_idx = 0;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input logic [DW-1:0] dd,
                      input logic ss, input logic ee,
                      input logic cc);
    int n;
    n = 0;
    bin_data = dd;
    bin_sop = ss;
    bin_eop = ee;
    bin_valid = 1;
    while (!bin_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("send_timeout", 1, 0);
      bin_valid = 0;
    end else begin
      clr_overrun = cc;
      model(dd, ss, ee, cc);
      if (chk_gap && prev_xfer >= 0)
        chk("ready_gap", cyc - prev_xfer, LP_GAP);
      prev_xfer = cyc;
      @(posedge clk);
      #1;
      bin_valid = 0;
      clr_overrun = 0;
      @(negedge clk);
      chk("overrun", overrun, ov_model);
    end
  endtask

  task automatic pulse_clr();
    clr_overrun = 1;
    @(posedge clk);
    #1;
    clr_overrun = 0;
    ov_model = 0;
    @(negedge clk);
    chk("overrun_clr", overrun, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    idle(3);
  endtask

  initial begin : main
    int n;
    logic s;
    logic e;
    logic after_eop;
    exp_t ex;
    for (int i = 0; i < 1024; i++) begin
      ref_ram[i] = '0;
      slave_ram[i] = '0;
    end
    reset_n = 0;
    bin_valid = 0;
    bin_data = '0;
    bin_sop = 0;
    bin_eop = 0;
    clr_overrun = 0;
    idle(3);
    chk("rst_write", avm_write, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_be", avm_byteenable, 4'hF);
    chk("rst_ready", bin_ready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1;
    idle(2);
    chk("ready_after_rst", bin_ready, 1);

`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
    send(32'd5, 1, 0, 0);
    send(32'd9, 0, 1, 0);
    send(32'd7, 1, 0, 0);
    send(32'd3, 0, 1, 0);
    drain();
    chk("peak_ram0", slave_ram[0], 32'd7);
    chk("peak_ram1", slave_ram[1], 32'd9);
`endif

    // Back-to-back 4-bin frame, no stalls.
    chk_gap = 1;
    prev_xfer = -1;
    send(32'h11, 1, 0, 0);
    send(32'h22, 0, 0, 0);
    send(32'h33, 0, 0, 0);
    send(32'h44, 0, 1, 0);
    chk_gap = 0;
    drain();

    // Three stall cycles on the second write.
    send(32'hA0, 1, 0, 0);
    drain();
    stall_cycles = 0;
    stall_left = 3;
    send(32'h22, 0, 0, 0);
    drain();
    chk("stall_cycles", stall_cycles, 3);
    send(32'hA2, 0, 1, 0);
    drain();

    // Six bins into four slots; eop on a dropped bin.
    for (int i = 0; i < 6; i++)
      send(32'h100 + i, i == 0, i == 5, 0);
    drain();
    chk("overrun_set", overrun, 1);
    pulse_clr();
    // Clear and new overrun together: set wins.
    for (int i = 0; i < 4; i++)
      send(32'h200 + i, i == 0, 0, 0);
    send(32'h204, 0, 0, 1);
    drain();
    chk("set_wins", overrun, 1);
    send(32'h300, 1, 1, 0);
    drain();
    pulse_clr();

    // sop mid-frame restarts at bin 0.
    send(32'hB0, 1, 0, 0);
    send(32'hB1, 0, 0, 0);
    send(32'hB2, 1, 0, 0);
    send(32'hB3, 0, 1, 0);
    drain();

    // Reset while a write is stalled.
    stall_left = 1000;
    send(32'hC0, 1, 0, 0);
    n = 0;
    while (!avm_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("write_seen", avm_write, 1);
    idle(2);
    #2;
    reset_n = 0;
    #1;
    chk("rst_mid_write", avm_write, 0);
    chk("rst_mid_ready", bin_ready, 0);
    while (q.size() > 0) begin
      ex = q.pop_back();
      ref_ram[ex.addr] = ex.old;
    end
    m_idx = 0;
    ov_model = 0;
    drop_fd = 0;
    stall_left = 0;
    idle(3);
    reset_n = 1;
    idle(2);
    send(32'hD0, 1, 0, 0);
    send(32'hD1, 0, 1, 0);
    drain();

    // Randomised frames with random stalls.
    rnd_wait = 1;
    after_eop = 1;
    for (int i = 0; i < 150; i++) begin
      if (after_eop) s = ($urandom_range(0, 3) != 0);
      else s = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 4) == 0);
`ifdef FFT_BIN_WRITER_PEAK_HOLD_EN
      send(DW'($urandom_range(0, 255)), s, e,
           $urandom_range(0, 9) == 0);
`else
      send($urandom, s, e, $urandom_range(0, 9) == 0);
`endif
      after_eop = e;
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) pulse_clr();
    end
    drain();
    rnd_wait = 0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bin_writer.md
Name: fft_bin_writer

Overview:
- Avalon-MM write master that drains the FFT magnitude stream into the 1024x32 single-port on-chip bin RAM (the s1 slave), one 32-bit word per bin.
- The VGA renderer reads the same RAM for display.
- Sits between the FFT output adapter (Avalon-ST style valid/ready with sop/eop) and the RAM slave port in vga_system.
- Tracks the bin index, honours waitrequest, and signals frame completion to the display controller.

Parameters:
- ADDR_W, 10, word-address width of the RAM slave.
- DATA_W, 32, bin word width; must equal the RAM data width.
- NUM_BINS, 1024, bins written per frame; must be ≤ 2**ADDR_W.
- BASE_ADDR, 0, word address of bin 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- bin_valid  in  1  stream word valid.
- bin_ready  out  1  stream backpressure.
- bin_data  in  DATA_W  bin magnitude.
- bin_sop  in  1  first bin of frame.
- bin_eop  in  1  last bin of frame.
- avm_address  out  ADDR_W  RAM word address.
- avm_write  out  1  write request.
- avm_read  out  1  read request (PEAK_HOLD_EN only, else tied 0).
- avm_writedata  out  DATA_W  write data.
- avm_byteenable  out  DATA_W/8  always all ones.
- avm_readdata  in  DATA_W  read data.
- avm_waitrequest  in  1  slave stall.
- frame_done  out  1  one-cycle pulse after the last bin write of a frame is accepted.
- overrun  out  1  sticky: a bin arrived with index ≥ NUM_BINS.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset values (async, reset_n low):
  - all outputs 0, except avm_byteenable, which is all ones.
  - index = 0; FSM = IDLE.
- Stream handshake:
  - A transfer occurs when bin_valid && bin_ready.
  - bin_ready = 1 only in IDLE.
- FSM states: IDLE, WRITE (plus RD, RDWAIT with PEAK_HOLD_EN).
- IDLE:
  - On transfer, latch data, sop and eop.
  - If sop, the effective index is 0; otherwise it is the index counter.
  - Effective index < NUM_BINS: go to WRITE.
  - Effective index ≥ NUM_BINS: drop the word, set overrun, stay in IDLE.
- WRITE:
  - Drive avm_write = 1, avm_address = BASE_ADDR + index (modulo 2**ADDR_W), avm_writedata = latched data.
  - Hold all three stable while avm_waitrequest = 1.
  - Write accepted on the first cycle with waitrequest = 0. Then index := index + 1, return to IDLE.
  - If the latched eop is set: pulse frame_done the cycle after acceptance, and reset index to 0.
- Latency and throughput:
  - Minimum stream-to-write latency is 1 cycle.
  - Peak throughput is one bin per 2 cycles.
- Counter width: index is ADDR_W+1 bits, so NUM_BINS = 2**ADDR_W is representable without wrap.
- Boundary conditions:
  - sop arriving mid-frame restarts at address BASE_ADDR; it is not an error.
  - sop and eop together form a 1-bin frame: write 1 word, then pulse frame_done.
  - eop on a dropped (overrun) bin still pulses frame_done in the cycle after the transfer, and resets index.
  - clr_overrun and a new overrun in the same cycle: the set wins.
  - reset_n asserted mid-write drops the write immediately. The RAM keeps whatever it had already accepted.

Optional Feature:
- Macro: FFT_BIN_WRITER_PEAK_HOLD_EN.
- When defined, each bin is read-modify-written: WRITE is preceded by RD and RDWAIT.
  - RD: drive avm_read = 1 and the address; hold it while waitrequest = 1.
  - RDWAIT: capture avm_readdata one cycle after the read is accepted (fixed read latency 1).
  - WRITE then writes max(bin_data, stored), unsigned.
  - On a sop bin, the stored value is ignored and bin_data is written unconditionally, so each frame starts fresh.
  - Throughput is one bin per 4 cycles minimum.
- When undefined: the RD and RDWAIT states are absent, avm_read is tied 0, and avm_readdata is unused.

Decomposition:
- Package fft_vga_pkg holds:
  - the FSM state enum;
  - the constants BIN_ADDR_W = 10, BIN_DATA_W = 32, BIN_COUNT = 1024, shared with the VGA renderer.
- No sub-module. Keep a single flat FSM with its datapath.

Test Plan:
- 4-bin frame, values 0x11, 0x22, 0x33, 0x44 with sop/eop, waitrequest = 0 → writes to addresses 0..3 with those data, byteenable 0xF, one frame_done pulse, bin_ready low every other cycle.
- waitrequest held high for 3 cycles on the second write → address 1 and data 0x22 stay stable for all 3 cycles, bin_ready = 0, exactly one write accepted.
- NUM_BINS = 4, send 6 bins with eop on the 6th → only addresses 0..3 written, overrun = 1, frame_done pulses once. clr_overrun then clears overrun.
- sop reasserted at bin 2 of a frame → that bin is written to address 0 and the next to address 1.
- reset_n pulsed low while avm_write is stalled → avm_write drops to 0 asynchronously. The next sop frame writes from address 0.
- PEAK_HOLD_EN: frame A = 5, 9 and frame B = 7, 3 (non-sop second bin) → RAM holds 7 and 9. Reads precede each write, and the sop bin is written without the max.
